trace_dispatch: RTL and testbench
=================================

# trace_dispatch

Front-end command sequencer between the trace-file reader and the L1 caches. It buffers trace records (command code `n` plus 32-bit address) in a small FIFO and routes each one in order. Data-side commands go to the data cache; instruction fetches go to the instruction cache. Clear and print commands become single-cycle control pulses to the caches and the statistics module. It gives the caches a valid/ready handshake so a stalled cache back-pressures the trace reader instead of losing records.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: trace address width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  trace record present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_n`  in  4  trace command code.
- `cmd_addr`  in  ADDR_W  trace address.
- `dc_valid`  out  1  request to the data cache.
- `dc_ready`  in  1  data cache accepts.
- `dc_n`  out  4  code forwarded (0, 1, 3 or 4).
- `dc_addr`  out  ADDR_W  address to the data cache.
- `ic_valid`  out  1  request to the instruction cache.
- `ic_ready`  in  1  instruction cache accepts.
- `ic_addr`  out  ADDR_W  address to the instruction cache.
- `clear`  out  1  one-cycle pulse: caches and statistics reset contents.
- `print`  out  1  one-cycle pulse: statistics module reports.
- `dropped`  out  32  count of unsupported codes discarded.

## Operation
- Push: a record enters the FIFO on an edge where `cmd_valid && cmd_ready`. A push is never accepted when the FIFO is full, even if a pop occurs on the same edge.
- Pop: the head record is popped on the edge where the FSM launches it. Launching also loads the output registers. Processing is strictly in order.
- Routing by code:
  - 0, 1, 3, 4 → data cache.
  - 2 → instruction cache.
  - 8 → clear.
  - 9 → print.
  - Any other code → discarded; `dropped` += 1 (saturates at 0xFFFFFFFF).
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head and go by code. Codes 0/1/3/4 → DC_WAIT with `dc_valid`=1. Code 2 → IC_WAIT with `ic_valid`=1. Code 8 → CLR. Code 9 → PRT. Any other code → stay in IDLE.
  - DC_WAIT: hold `dc_valid`, `dc_n` and `dc_addr` stable until an edge with `dc_ready`=1. On that edge drop `dc_valid`. If the FIFO is non-empty, launch the next head on the same edge (back-to-back); otherwise go to IDLE.
  - IC_WAIT: same as DC_WAIT, using `ic_*`.
  - CLR: `clear`=1 for exactly one cycle. `dropped` is zeroed on the same edge. Then continue as from IDLE.
  - PRT: `print`=1 for exactly one cycle. Then continue as from IDLE.
- A clear or print never overlaps an outstanding cache request; in-order issue guarantees this.
- `dc_addr` and `ic_addr` retain their last value when not valid. `dc_n` retains its last value.

## Timing
- Reset (async assert, sync release):
  - FIFO empty; FSM in IDLE.
  - `cmd_ready`=1; `dc_valid`=`ic_valid`=`clear`=`print`=0.
  - `dc_n`=0; `dc_addr`=`ic_addr`=0; `dropped`=0.
- Latency: a record accepted into an empty FIFO on edge E appears on `dc_valid`/`ic_valid` (or as a `clear`/`print` pulse) after edge E+1.
- Throughput: one request per cycle when the cache holds ready=1.
- Discarded codes consume one cycle each. `dropped` updates after the pop edge.
- Reset asserted mid-transaction immediately drops all valids and pulses and empties the FIFO. Any in-flight request is lost; none is replayed.
- `cmd_ready` falls after the edge on which the FIFO becomes full. It rises after the first subsequent pop.
- FIFO pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.

## Test plan
- Reset with `dc_ready`=`ic_ready`=1, then push (0,0x1000), (2,0x2000), (1,0x3000) back-to-back.
  - Required: `dc_valid` with n=0, addr 0x1000 at cycle E+1; `ic_valid` with 0x2000 at E+2; `dc_valid` with n=1, 0x3000 at E+3.
- Hold `dc_ready`=0 and push 6 records with code 0.
  - Required: `cmd_ready` low after 4 FIFO entries plus 1 in the output register; `dc_addr` stable.
  - Then release `dc_ready`: all 6 are issued in order with no loss.
- Push codes 5, 7, 15, then 8.
  - Required: `dropped` goes 1, 2, 3; then `clear` pulses for one cycle and `dropped` returns to 0.
- Push (0,0xA), 9, (3,0xB) with `dc_ready` held low for 3 cycles.
  - Required: `print` pulses only after 0xA is accepted; 0xB is issued the cycle after the `print` pulse.
- Assert `rst_n` low while `dc_valid`=1 with 3 entries queued.
  - Required: `dc_valid`=0 immediately; after release, no stale record is issued and `cmd_ready`=1.

Source files
------------

// File: rtl/trace_dispatch_if.sv
// rtl/trace_dispatch_if.sv - trace record intake and cache request handshake bundle
//
// Groups every non-clock signal of trace_dispatch.
//   cmd_*     trace record from the reader (valid/ready, 4-bit code, address)
//   dc_*      data-cache request (valid/ready, forwarded code, address)
//   ic_*      instruction-cache request (valid/ready, address)
//   clear     one-cycle pulse: caches and statistics reset contents
//   print     one-cycle pulse: statistics module reports
//   dropped   count of unsupported codes discarded
// modport slave  : the dispatcher's view
// modport master : the view of the reader/caches surrounding it
interface trace_dispatch_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_n;
    logic [ADDR_W-1:0] cmd_addr;

    logic              dc_valid;
    logic              dc_ready;
    logic [3:0]        dc_n;
    logic [ADDR_W-1:0] dc_addr;

    logic              ic_valid;
    logic              ic_ready;
    logic [ADDR_W-1:0] ic_addr;

    logic              clear;
    logic              print;
    logic [31:0]       dropped;

    modport slave (
        input  cmd_valid, cmd_n, cmd_addr, dc_ready, ic_ready,
        output cmd_ready, dc_valid, dc_n, dc_addr, ic_valid, ic_addr,
               clear, print, dropped
    );

    modport master (
        output cmd_valid, cmd_n, cmd_addr, dc_ready, ic_ready,
        input  cmd_ready, dc_valid, dc_n, dc_addr, ic_valid, ic_addr,
               clear, print, dropped
    );
endinterface

// File: rtl/trace_dispatch.sv
// rtl/trace_dispatch.sv - in-order trace command sequencer feeding the L1 caches
//
// Buffers trace records in a DEPTH-entry FIFO and issues them strictly in
// order: codes 0/1/3/4 to the data cache, code 2 to the instruction cache,
// code 8 as a clear pulse, code 9 as a print pulse; anything else is
// discarded and counted in dropped (saturating).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    trace_dispatch_if.slave (cmd_*, dc_*, ic_*, clear, print, dropped)
module trace_dispatch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    trace_dispatch_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC_WAIT,
        S_IC_WAIT,
        S_CLR,
        S_PRT
    } state_t;

    // ------------------------------------------------------------------
    // Record FIFO. Pointers carry one extra wrap bit so full and empty
    // are distinguishable with all DEPTH slots in use.
    // ------------------------------------------------------------------
    logic [3:0]        mem_n    [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [3:0]        head_n;
    logic [ADDR_W-1:0] head_addr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Acceptance looks only at the registered full flag, so a pop on the
    // same edge never lets an extra record slip into a full FIFO.
    assign push      = bus.cmd_valid && !full;
    assign head_n    = mem_n[rd_ptr[PTR_W-1:0]];
    assign head_addr = mem_addr[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wr_ptr[PTR_W-1:0]]    <= bus.cmd_n;
            mem_addr[wr_ptr[PTR_W-1:0]] <= bus.cmd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head-of-queue decode
    // ------------------------------------------------------------------
    logic head_dc;
    logic head_ic;
    logic head_clr;
    logic head_prt;
    logic head_drop;

    always_comb begin
        head_dc   = 1'b0;
        head_ic   = 1'b0;
        head_clr  = 1'b0;
        head_prt  = 1'b0;
        head_drop = 1'b0;
        case (head_n)
            4'd0, 4'd1, 4'd3, 4'd4: head_dc   = 1'b1;
            4'd2:                   head_ic   = 1'b1;
            4'd8:                   head_clr  = 1'b1;
            4'd9:                   head_prt  = 1'b1;
            default:                head_drop = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue FSM. "free" means the current slot finishes this cycle, so
    // the head can be launched on the same edge (back-to-back issue).
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   free;
    logic   launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        free    = 1'b0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE:    free = 1'b1;
            S_CLR:     free = 1'b1;
            S_PRT:     free = 1'b1;
            S_DC_WAIT: free = bus.dc_ready;
            S_IC_WAIT: free = bus.ic_ready;
            default:   free = 1'b1;
        endcase
        if (free) begin
            state_d = S_IDLE;
            if (!empty) begin
                launch = 1'b1;
                if (head_dc) begin
                    state_d = S_DC_WAIT;
                end else if (head_ic) begin
                    state_d = S_IC_WAIT;
                end else if (head_clr) begin
                    state_d = S_CLR;
                end else if (head_prt) begin
                    state_d = S_PRT;
                end
            end
        end
    end

    assign pop = launch;

    // ------------------------------------------------------------------
    // Output registers: loaded only on launch so they hold their last
    // value while idle or stalled.
    // ------------------------------------------------------------------
    logic [3:0]        dc_n_q;
    logic [ADDR_W-1:0] dc_addr_q;
    logic [ADDR_W-1:0] ic_addr_q;
    logic [31:0]       dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_n_q    <= '0;
            dc_addr_q <= '0;
            ic_addr_q <= '0;
        end else begin
            if (launch && head_dc) begin
                dc_n_q    <= head_n;
                dc_addr_q <= head_addr;
            end
            if (launch && head_ic) begin
                ic_addr_q <= head_addr;
            end
        end
    end

    // The clear launch zeroes the counter, so it already reads 0 while the
    // clear pulse is visible to the statistics module.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_q <= '0;
        end else if (launch && head_clr) begin
            dropped_q <= '0;
        end else if (launch && head_drop && (dropped_q != 32'hFFFF_FFFF)) begin
            dropped_q <= dropped_q + 32'd1;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.dc_valid  = (state_q == S_DC_WAIT);
    assign bus.ic_valid  = (state_q == S_IC_WAIT);
    assign bus.clear     = (state_q == S_CLR);
    assign bus.print     = (state_q == S_PRT);
    assign bus.dc_n      = dc_n_q;
    assign bus.dc_addr   = dc_addr_q;
    assign bus.ic_addr   = ic_addr_q;
    assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_trace_dispatch.sv
// tb/tb_trace_dispatch.sv - self-checking bench for trace_dispatch
module tb_trace_dispatch;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trace_dispatch_if #(.ADDR_W(ADDR_W)) bus ();

    trace_dispatch #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef enum int {EV_DC, EV_IC, EV_CLR, EV_PRT, EV_DROP} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [3:0]  n;
        logic [31:0] addr;
    } ev_t;

    ev_t exp_q[$];

    function automatic ev_kind_t classify(input logic [3:0] n);
        if (n == 4'd0 || n == 4'd1 || n == 4'd3 || n == 4'd4) return EV_DC;
        if (n == 4'd2) return EV_IC;
        if (n == 4'd8) return EV_CLR;
        if (n == 4'd9) return EV_PRT;
        return EV_DROP;
    endfunction

    task automatic drive_cmd(input logic v, input logic [3:0] n, input logic [31:0] a);
        bus.cmd_valid = v;
        bus.cmd_n     = n;
        bus.cmd_addr  = a;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_cmd(1'b0, 4'd0, 32'd0);
        bus.dc_ready = 1'b1;
        bus.ic_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_cmd(1'b0, 4'd0, 32'd0);
        bus.dc_ready = 1'b1;
        bus.ic_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.dc_valid !== 1'b0) begin failures++; $display("FAIL reset_dc_valid: got %b expected 0", bus.dc_valid); end
        checks++; if (bus.ic_valid !== 1'b0) begin failures++; $display("FAIL reset_ic_valid: got %b expected 0", bus.ic_valid); end
        checks++; if (bus.clear !== 1'b0) begin failures++; $display("FAIL reset_clear: got %b expected 0", bus.clear); end
        checks++; if (bus.print !== 1'b0) begin failures++; $display("FAIL reset_print: got %b expected 0", bus.print); end
        checks++; if (bus.dc_n !== 4'd0) begin failures++; $display("FAIL reset_dc_n: got %0d expected 0", bus.dc_n); end
        checks++; if (bus.dc_addr !== 32'd0) begin failures++; $display("FAIL reset_dc_addr: got %h expected 0", bus.dc_addr); end
        checks++; if (bus.ic_addr !== 32'd0) begin failures++; $display("FAIL reset_ic_addr: got %h expected 0", bus.ic_addr); end
        checks++; if (bus.dropped !== 32'd0) begin failures++; $display("FAIL reset_dropped: got %0d expected 0", bus.dropped); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.dc_valid !== 1'b0) begin failures++; $display("FAIL reset_release: got ready=%b dc_valid=%b expected 1/0", bus.cmd_ready, bus.dc_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, 32'h1000);
        @(negedge clk);
        checks++; if (bus.dc_valid !== 1'b0 || bus.ic_valid !== 1'b0) begin failures++; $display("FAIL b2b_latency: got dc=%b ic=%b expected 0/0", bus.dc_valid, bus.ic_valid); end
        drive_cmd(1'b1, 4'd2, 32'h2000);
        @(negedge clk);
        checks++; if (bus.dc_valid !== 1'b1 || bus.dc_n !== 4'd0 || bus.dc_addr !== 32'h1000 || bus.ic_valid !== 1'b0) begin failures++; $display("FAIL b2b_first: got v=%b n=%0d a=%h expected 1/0/1000", bus.dc_valid, bus.dc_n, bus.dc_addr); end
        drive_cmd(1'b1, 4'd1, 32'h3000);
        @(negedge clk);
        checks++; if (bus.ic_valid !== 1'b1 || bus.ic_addr !== 32'h2000 || bus.dc_valid !== 1'b0) begin failures++; $display("FAIL b2b_second: got ic=%b a=%h dc=%b expected 1/2000/0", bus.ic_valid, bus.ic_addr, bus.dc_valid); end
        drive_cmd(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.dc_valid !== 1'b1 || bus.dc_n !== 4'd1 || bus.dc_addr !== 32'h3000 || bus.ic_valid !== 1'b0) begin failures++; $display("FAIL b2b_third: got v=%b n=%0d a=%h expected 1/1/3000", bus.dc_valid, bus.dc_n, bus.dc_addr); end
        @(negedge clk);
        checks++; if (bus.dc_valid !== 1'b0 || bus.dc_addr !== 32'h3000 || bus.dc_n !== 4'd1 || bus.ic_addr !== 32'h2000) begin failures++; $display("FAIL b2b_retain: got v=%b n=%0d dca=%h ica=%h expected 0/1/3000/2000", bus.dc_valid, bus.dc_n, bus.dc_addr, bus.ic_addr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] recs [6];
        int  idx;
        bit  sent5;
        apply_reset();
        bus.dc_ready = 1'b0;
        for (int i = 0; i < 6; i++) recs[i] = (32'(i) << 24) | ($urandom() & 32'h00FF_FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_early[%0d]: got %b expected 1", i, bus.cmd_ready); end
            drive_cmd(1'b1, 4'd0, recs[i]);
        end
        @(negedge clk);
        drive_cmd(1'b1, 4'd0, recs[5]);
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got %b expected 0", bus.cmd_ready); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.dc_valid !== 1'b1 || bus.dc_addr !== recs[0] || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_hold: got v=%b a=%h rdy=%b expected 1/%h/0", bus.dc_valid, bus.dc_addr, bus.cmd_ready, recs[0]); end
        end
        idx   = 0;
        sent5 = 1'b0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            @(negedge clk);
            bus.dc_ready = 1'b1;
            if (sent5) bus.cmd_valid = 1'b0;
            else if (bus.cmd_ready) sent5 = 1'b1;
            if (bus.dc_valid) begin
                checks++; if (bus.dc_addr !== recs[idx] || bus.dc_n !== 4'd0) begin failures++; $display("FAIL bp_order[%0d]: got a=%h n=%0d expected %h/0", idx, bus.dc_addr, bus.dc_n, recs[idx]); end
                idx++;
            end
        end
        drive_cmd(1'b0, 4'd0, 32'd0);
        checks++; if (idx != 6) begin failures++; $display("FAIL bp_count: got %0d expected 6", idx); end
    endtask

    task automatic test_drop_clear();
        logic [3:0] codes [4];
        codes[0] = 4'd5; codes[1] = 4'd7; codes[2] = 4'd15; codes[3] = 4'd8;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                checks++; if (bus.dropped !== 32'(k - 1)) begin failures++; $display("FAIL drop_count[%0d]: got %0d expected %0d", k, bus.dropped, k - 1); end
                checks++; if (bus.clear !== 1'b0) begin failures++; $display("FAIL drop_no_clear[%0d]: got %b expected 0", k, bus.clear); end
            end
            if (k == 5) begin
                checks++; if (bus.clear !== 1'b1) begin failures++; $display("FAIL clear_pulse: got %b expected 1", bus.clear); end
            end
            if (k == 6) begin
                checks++; if (bus.clear !== 1'b0 || bus.dropped !== 32'd0) begin failures++; $display("FAIL clear_after: got clear=%b dropped=%0d expected 0/0", bus.clear, bus.dropped); end
            end
            if (k < 4) drive_cmd(1'b1, codes[k], 32'(k));
            else drive_cmd(1'b0, 4'd0, 32'd0);
        end
    endtask

    task automatic test_print_order();
        bit a_done;
        int print_cnt;
        int print_cyc;
        int b_cyc;
        apply_reset();
        bus.dc_ready = 1'b0;
        a_done = 1'b0; print_cnt = 0; print_cyc = -10; b_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) drive_cmd(1'b1, 4'd0, 32'hA);
            else if (c == 1) drive_cmd(1'b1, 4'd9, 32'h0);
            else if (c == 2) drive_cmd(1'b1, 4'd3, 32'hB);
            else drive_cmd(1'b0, 4'd0, 32'd0);
            bus.dc_ready = (c >= 5);
            if (bus.print) begin
                checks++; if (!a_done) begin failures++; $display("FAIL print_early: got print at cycle %0d expected after 0xA accepted", c); end
                print_cnt++;
                print_cyc = c;
            end
            if (bus.dc_valid && bus.dc_ready) begin
                if (bus.dc_addr == 32'hA) a_done = 1'b1;
                else if (bus.dc_addr == 32'hB) begin
                    b_cyc = c;
                    checks++; if (bus.dc_n !== 4'd3) begin failures++; $display("FAIL print_b_code: got %0d expected 3", bus.dc_n); end
                end
            end
        end
        checks++; if (print_cnt != 1) begin failures++; $display("FAIL print_count: got %0d expected 1", print_cnt); end
        checks++; if (b_cyc != print_cyc + 1) begin failures++; $display("FAIL print_then_b: got b at %0d expected %0d", b_cyc, print_cyc + 1); end
    endtask

    task automatic test_reset_midflight();
        bit saw_valid;
        apply_reset();
        bus.dc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_cmd(1'b1, 4'd0, 32'h5000 + 32'(i));
        end
        @(negedge clk);
        drive_cmd(1'b0, 4'd0, 32'd0);
        checks++; if (bus.dc_valid !== 1'b1 || bus.dc_addr !== 32'h5000) begin failures++; $display("FAIL midrst_pre: got v=%b a=%h expected 1/5000", bus.dc_valid, bus.dc_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.dc_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_async: got v=%b rdy=%b expected 0/1", bus.dc_valid, bus.cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.dc_ready = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.dc_valid || bus.ic_valid || bus.clear || bus.print) saw_valid = 1'b1;
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL midrst_stale: got issue after reset expected none"); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_random();
        ev_t         obs;
        ev_t         e;
        bit          obs_v;
        bit          dcr;
        bit          icr;
        bit          held_dc;
        bit          held_ic;
        logic [3:0]  held_n;
        logic [31:0] held_dca;
        logic [31:0] held_ica;
        logic [3:0]  n;
        int          r;
        int          model_dropped;
        bit          ok;
        apply_reset();
        exp_q.delete();
        model_dropped = 0;
        held_dc = 1'b0; held_ic = 1'b0;
        held_n = '0; held_dca = '0; held_ica = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if ($countones({bus.dc_valid, bus.ic_valid, bus.clear, bus.print}) > 1) begin failures++; $display("FAIL rnd_overlap[%0d]: got dc=%b ic=%b clr=%b prt=%b expected at most one", c, bus.dc_valid, bus.ic_valid, bus.clear, bus.print); end
            if (held_dc) begin
                checks++; if (bus.dc_valid !== 1'b1 || bus.dc_n !== held_n || bus.dc_addr !== held_dca) begin failures++; $display("FAIL rnd_dc_stable[%0d]: got v=%b n=%0d a=%h expected 1/%0d/%h", c, bus.dc_valid, bus.dc_n, bus.dc_addr, held_n, held_dca); end
            end
            if (held_ic) begin
                checks++; if (bus.ic_valid !== 1'b1 || bus.ic_addr !== held_ica) begin failures++; $display("FAIL rnd_ic_stable[%0d]: got v=%b a=%h expected 1/%h", c, bus.ic_valid, bus.ic_addr, held_ica); end
            end
            dcr = (c >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            icr = (c >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.dc_ready = dcr;
            bus.ic_ready = icr;
            held_dc  = bus.dc_valid && !dcr;
            held_ic  = bus.ic_valid && !icr;
            held_n   = bus.dc_n;
            held_dca = bus.dc_addr;
            held_ica = bus.ic_addr;

            obs_v = 1'b1;
            obs.n = bus.dc_n;
            obs.addr = bus.dc_addr;
            if (bus.dc_valid && dcr) obs.kind = EV_DC;
            else if (bus.ic_valid && icr) begin obs.kind = EV_IC; obs.addr = bus.ic_addr; end
            else if (bus.clear) obs.kind = EV_CLR;
            else if (bus.print) obs.kind = EV_PRT;
            else obs_v = 1'b0;
            if (obs_v) begin
                while (exp_q.size() > 0 && exp_q[0].kind == EV_DROP) begin
                    void'(exp_q.pop_front());
                    model_dropped++;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_unexpected[%0d]: got event kind %0d expected none", c, obs.kind);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (e.kind == obs.kind);
                    if (e.kind == EV_DC && (e.n !== obs.n || e.addr !== obs.addr)) ok = 1'b0;
                    if (e.kind == EV_IC && e.addr !== obs.addr) ok = 1'b0;
                    if (!ok) begin failures++; $display("FAIL rnd_event[%0d]: got kind=%0d n=%0d a=%h expected kind=%0d n=%0d a=%h", c, obs.kind, obs.n, obs.addr, e.kind, e.n, e.addr); end
                    if (e.kind == EV_CLR) model_dropped = 0;
                    else begin
                        checks++; if (bus.dropped !== 32'(model_dropped)) begin failures++; $display("FAIL rnd_dropped[%0d]: got %0d expected %0d", c, bus.dropped, model_dropped); end
                    end
                end
            end

            if (c < 300 && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    case (r) 0: n = 4'd0; 1: n = 4'd1; 2: n = 4'd3; default: n = 4'd4; endcase
                end else if (r < 6) n = 4'd2;
                else if (r == 6) n = 4'd8;
                else if (r == 7) n = 4'd9;
                else n = 4'($urandom_range(0, 15));
                drive_cmd(1'b1, n, $urandom());
                if (bus.cmd_ready) begin
                    e.kind = classify(n);
                    e.n    = n;
                    e.addr = bus.cmd_addr;
                    exp_q.push_back(e);
                end
            end else begin
                drive_cmd(1'b0, 4'd0, 32'd0);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].kind == EV_DROP) begin
            void'(exp_q.pop_front());
            model_dropped++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain: got %0d records left expected 0", exp_q.size()); end
        checks++; if (bus.dropped !== 32'(model_dropped)) begin failures++; $display("FAIL rnd_final_dropped: got %0d expected %0d", bus.dropped, model_dropped); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_cmd(1'b0, 4'd0, 32'd0);
        bus.dc_ready = 1'b1;
        bus.ic_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_drop_clear();
        test_print_order();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
